// File: rtl/ex_divider_pkg.sv
// Shared definitions for the EX-stage iterative divider.
//   DATA_W     : operand / result width
//   DIV_CYCLES : restoring iterations per divide
//   COUNT_W    : iteration counter width
//   div_state_e: divider FSM encoding
package ex_divider_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned DIV_CYCLES = 32;
  localparam int unsigned COUNT_W    = 6;
  localparam int unsigned REM_W      = DATA_W + 1;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/ex_divider_sign_fix.sv
// Sign handling for signed divide: magnitude extraction on the way in and
// sign restoration of quotient/remainder on the way out. Purely combinational.
//   is_signed          : 1 = DIV, 0 = DIVU
//   dividend, divisor  : raw operands
//   quo_mag, rem_mag   : unsigned quotient / remainder from the iteration
//   neg_quo, neg_rem   : sign flags latched at start
//   dividend_mag_c     : |dividend| (or dividend when unsigned)
//   divisor_mag_c      : |divisor|  (or divisor when unsigned)
//   neg_quo_c          : quotient must be negated (operand signs differ)
//   neg_rem_c          : remainder must be negated (dividend negative)
//   quo_c, rem_c       : signed-corrected results
module ex_divider_sign_fix
  import ex_divider_pkg::*;
(
  input  logic              is_signed,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  input  logic [DATA_W-1:0] quo_mag,
  input  logic [DATA_W-1:0] rem_mag,
  input  logic              neg_quo,
  input  logic              neg_rem,
  output logic [DATA_W-1:0] dividend_mag_c,
  output logic [DATA_W-1:0] divisor_mag_c,
  output logic              neg_quo_c,
  output logic              neg_rem_c,
  output logic [DATA_W-1:0] quo_c,
  output logic [DATA_W-1:0] rem_c
);

  logic dividend_neg;
  logic divisor_neg;

  // 0x80000000 negates to itself, which is the correct unsigned magnitude
  always_comb begin
    dividend_neg   = is_signed & dividend[DATA_W-1];
    divisor_neg    = is_signed & divisor[DATA_W-1];
    dividend_mag_c = dividend_neg ? (~dividend + DATA_W'(1)) : dividend;
    divisor_mag_c  = divisor_neg  ? (~divisor  + DATA_W'(1)) : divisor;
    neg_quo_c      = dividend_neg ^ divisor_neg;
    neg_rem_c      = dividend_neg;
    quo_c          = neg_quo ? (~quo_mag + DATA_W'(1)) : quo_mag;
    rem_c          = neg_rem ? (~rem_mag + DATA_W'(1)) : rem_mag;
  end

endmodule

// File: rtl/ex_divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the EX stage.
// Holds the pipeline via stall_req while iterating; pulses done for one
// cycle when hi (remainder) / lo (quotient) carry a fresh result.
//   clk, rst             : clock, synchronous active-high reset
//   start, is_signed     : divide request and sign mode (sampled in IDLE)
//   flush                : annul any in-flight divide
//   operand_1, operand_2 : dividend, divisor
//   stall_req            : combinational pipeline hold
//   done                 : one-cycle completion pulse
//   hi, lo               : remainder, quotient (held until next completion)
module ex_divider
  import ex_divider_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_signed,
  input  logic              flush,
  input  logic [DATA_W-1:0] operand_1,
  input  logic [DATA_W-1:0] operand_2,
  output logic              stall_req,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  div_state_e         state_q, state_d;
  logic [COUNT_W-1:0] count_q;
  logic [REM_W-1:0]   rem_q;
  logic [DATA_W-1:0]  quo_q;
  logic [DATA_W-1:0]  dvs_q;
  logic               neg_quo_q, neg_rem_q;

  logic               load, div_zero, step, last;
  logic [REM_W:0]     shifted, diff;
  logic               keep;
  logic [REM_W-1:0]   rem_step;
  logic [DATA_W-1:0]  quo_step;

  logic [DATA_W-1:0]  dividend_mag, divisor_mag, quo_fix, rem_fix;
  logic               neg_quo, neg_rem;

  ex_divider_sign_fix u_sign_fix (
    .is_signed      (is_signed),
    .dividend       (operand_1),
    .divisor        (operand_2),
    .quo_mag        (quo_step),
    .rem_mag        (rem_step[DATA_W-1:0]),
    .neg_quo        (neg_quo_q),
    .neg_rem        (neg_rem_q),
    .dividend_mag_c (dividend_mag),
    .divisor_mag_c  (divisor_mag),
    .neg_quo_c      (neg_quo),
    .neg_rem_c      (neg_rem),
    .quo_c          (quo_fix),
    .rem_c          (rem_fix)
  );

  // One restoring step: shift {rem, quo} left, trial-subtract divisor magnitude
  always_comb begin
    shifted  = {rem_q, quo_q[DATA_W-1]};
    diff     = shifted - (REM_W+1)'(dvs_q);
    keep     = (shifted >= (REM_W+1)'(dvs_q));
    rem_step = keep ? REM_W'(diff) : REM_W'(shifted);
    quo_step = {quo_q[DATA_W-2:0], keep};
  end

  // Next-state and control decode; flush overrides start and iteration
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    div_zero = 1'b0;
    step     = 1'b0;
    last     = (count_q == COUNT_W'(DIV_CYCLES - 1));
    unique case (state_q)
      DIV_IDLE: begin
        if (start && !flush) begin
          load = 1'b1;
          if (operand_2 == '0) begin
            div_zero = 1'b1;
            state_d  = DIV_DONE;
          end else begin
            state_d  = DIV_BUSY;
          end
        end
      end
      DIV_BUSY: begin
        if (flush) begin
          state_d = DIV_IDLE;
        end else begin
          step = 1'b1;
          if (last) state_d = DIV_DONE;
        end
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  always_comb begin
    stall_req = ((state_q == DIV_IDLE) && start && !flush) ||
                ((state_q == DIV_BUSY) && !flush);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= DIV_IDLE;
    else     state_q <= state_d;
  end

  // Iteration datapath, counter and registered results
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      done      <= 1'b0;
    end else begin
      if (load) begin
        count_q   <= '0;
        rem_q     <= '0;
        quo_q     <= dividend_mag;
        dvs_q     <= divisor_mag;
        neg_quo_q <= neg_quo;
        neg_rem_q <= neg_rem;
      end else if (step) begin
        count_q   <= count_q + COUNT_W'(1);
        rem_q     <= rem_step;
        quo_q     <= quo_step;
      end
      if (div_zero) begin
        hi <= operand_1;
        lo <= '1;
      end else if (step && last) begin
        hi <= rem_fix;
        lo <= quo_fix;
      end
      done <= (state_d == DIV_DONE);
    end
  end

endmodule

// File: tb/tb_ex_divider.sv
// Directed self-checking bench for ex_divider.
module tb_ex_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic        flush;
  logic [31:0] operand_1;
  logic [31:0] operand_2;
  logic        stall_req;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fails  = 0;

  ex_divider dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .flush     (flush),
    .operand_1 (operand_1),
    .operand_2 (operand_2),
    .stall_req (stall_req),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue one divide, then follow it to completion checking stall, latency and results
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi, input int exp_lat);
    int   lat;
    logic stall_ok;
    start = 1'b1; is_signed = sgn; operand_1 = a; operand_2 = b;
    #1;
    check({tag, " stall@T"}, 32'(stall_req), 32'd1);
    cyc();
    start = 1'b0; operand_1 = '0; operand_2 = '0; is_signed = 1'b0;
    #1;
    lat = 1;
    stall_ok = 1'b1;
    while (!done && lat < 40) begin
      if (!stall_req) stall_ok = 1'b0;
      cyc();
      #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " stall while busy"}, 32'(stall_ok), 32'd1);
    check({tag, " lo"}, lo, exp_lo);
    check({tag, " hi"}, hi, exp_hi);
    check({tag, " stall@done"}, 32'(stall_req), 32'd0);
    cyc();
    check({tag, " done one cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; flush = 1'b0;
    operand_1 = '0; operand_2 = '0;
    cyc(); cyc();
    check("reset done", 32'(done), 32'd0);
    check("reset stall", 32'(stall_req), 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    rst = 1'b0;
    cyc();

    run_div("divu 100/7",       1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33);
    run_div("div -7/2",         1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  33);
    run_div("div 7/-2",         1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          33);
    run_div("div min/-1",       1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33);
    run_div("divu min/max",     1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  33);
    run_div("divu max/1",       1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          33);
    run_div("divu 0x1234/0",    1'b0, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234,  1);
    run_div("div -5/0",         1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  1);
    run_div("divu 1000/3",      1'b0, 32'd1000,       32'd3,          32'd333,        32'd1,          33);

    // Flush at T+10: no done, results untouched, restart at T+11 completes at T+44
    begin
      logic saw_done;
      saw_done = 1'b0;
      start = 1'b1; is_signed = 1'b0; operand_1 = 32'd500; operand_2 = 32'd9;
      cyc();
      start = 1'b0;
      for (int i = 1; i < 10; i++) begin
        if (done) saw_done = 1'b1;
        cyc();
      end
      flush = 1'b1;
      #1;
      check("flush stall drop", 32'(stall_req), 32'd0);
      cyc();
      flush = 1'b0;
      if (done) saw_done = 1'b1;
      check("flush no done", 32'(saw_done), 32'd0);
      check("flush hi kept", hi, 32'd1);
      check("flush lo kept", lo, 32'd333);
      run_div("after flush 77/5", 1'b0, 32'd77, 32'd5, 32'd15, 32'd2, 33);
    end

    // Reset at T+5 clears everything
    start = 1'b1; is_signed = 1'b1; operand_1 = 32'd40; operand_2 = 32'd6;
    cyc();
    start = 1'b0;
    for (int i = 1; i < 5; i++) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("midrst hi", hi, 32'd0);
    check("midrst lo", lo, 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst stall", 32'(stall_req), 32'd0);

    // start during BUSY is ignored; result follows the first operands
    begin
      int lat;
      start = 1'b1; is_signed = 1'b0; operand_1 = 32'd1000; operand_2 = 32'd10;
      cyc();
      start = 1'b0;
      cyc(); cyc();
      start = 1'b1; operand_1 = 32'd55; operand_2 = 32'd0;
      cyc();
      start = 1'b0; operand_1 = '0; operand_2 = '0;
      lat = 4;
      while (!done && lat < 40) begin
        cyc();
        lat++;
      end
      check("busy start latency", 32'(lat), 32'd33);
      check("busy start lo", lo, 32'd100);
      check("busy start hi", hi, 32'd0);
      // start in DONE is ignored as well
      start = 1'b1; operand_1 = 32'd9; operand_2 = 32'd3;
      cyc();
      start = 1'b0;
      #1;
      check("done start ignored stall", 32'(stall_req), 32'd0);
      cyc();
      check("done start ignored done", 32'(done), 32'd0);
      check("done start ignored lo", lo, 32'd100);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
